// File: rtl/epl_xfer_scheduler.sv
// Transfer scheduler for the EPL shift engine: arbitrates host writes, interrupt
// refreshes and periodic polls onto a single start/busy/done engine port.
module epl_xfer_scheduler #(
    parameter int POLL_DIV = 1000,
    parameter int TIMEOUT  = 4096
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic        host_req,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    output logic [31:0] host_rdata,
    input  logic        poll_en,
    input  logic        epl_int,
    output logic        eng_start,
    output logic [31:0] eng_txdata,
    input  logic        eng_busy,
    input  logic        eng_done,
    input  logic [31:0] eng_rxdata,
    output logic [31:0] last_rx,
    output logic [1:0]  last_src,
    output logic        irq,
    input  logic        irq_clr,
    output logic        err,
    input  logic        err_clr
);

    localparam int PW = $clog2(POLL_DIV);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] SRC_HOST = 2'd1;
    localparam logic [1:0] SRC_INT  = 2'd2;
    localparam logic [1:0] SRC_POLL = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t        state_reg;
    logic          int_sync1_reg, int_sync2_reg, int_prev_reg;
    logic          int_pend_reg, poll_pend_reg;
    logic [PW-1:0] poll_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic [31:0]   shadow_reg;
    logic [1:0]    src_reg;
    logic          last_host_reg;

    logic int_rise, poll_tc, tmo_hit;
    logic grant_host, grant_int, grant_poll, any_grant;
    logic irq_set, err_set;

    assign int_rise  = int_sync2_reg & ~int_prev_reg;
    assign poll_tc   = poll_en && (poll_cnt_reg == PW'(POLL_DIV - 1));
    assign tmo_hit   = (tmo_cnt_reg == TW'(TIMEOUT - 1));
    assign any_grant = grant_host | grant_int | grant_poll;
    assign irq_set   = (state_reg == ST_WAIT) && eng_done && (src_reg == SRC_INT);
    assign err_set   = (state_reg == ST_WAIT) && !eng_done && tmo_hit;

    // After a host grant, pending int/poll work goes first so a host that keeps
    // re-requesting cannot starve the refresh sources.
    always_comb begin
        grant_host = 1'b0;
        grant_int  = 1'b0;
        grant_poll = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (last_host_reg && (int_pend_reg || poll_pend_reg)) begin
                if (int_pend_reg) grant_int  = 1'b1;
                else              grant_poll = 1'b1;
            end else if (host_req) begin
                grant_host = 1'b1;
            end else if (int_pend_reg) begin
                grant_int = 1'b1;
            end else if (poll_pend_reg) begin
                grant_poll = 1'b1;
            end
        end
    end

    // Event capture: a new event in the grant cycle re-sets its pend flag.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            int_sync1_reg <= 1'b0;
            int_sync2_reg <= 1'b0;
            int_prev_reg  <= 1'b0;
            int_pend_reg  <= 1'b0;
            poll_pend_reg <= 1'b0;
            poll_cnt_reg  <= '0;
        end else begin
            int_sync1_reg <= epl_int;
            int_sync2_reg <= int_sync1_reg;
            int_prev_reg  <= int_sync2_reg;
            if (int_rise)       int_pend_reg <= 1'b1;
            else if (grant_int) int_pend_reg <= 1'b0;
            if (!poll_en) begin
                poll_cnt_reg  <= '0;
                poll_pend_reg <= 1'b0;
            end else begin
                poll_cnt_reg <= poll_tc ? '0 : poll_cnt_reg + PW'(1);
                if (poll_tc)         poll_pend_reg <= 1'b1;
                else if (grant_poll) poll_pend_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state_reg     <= ST_IDLE;
            tmo_cnt_reg   <= '0;
            shadow_reg    <= '0;
            src_reg       <= 2'd0;
            last_host_reg <= 1'b0;
            eng_start     <= 1'b0;
            eng_txdata    <= '0;
            host_ack      <= 1'b0;
            host_rdata    <= '0;
            last_rx       <= '0;
            last_src      <= 2'd0;
            irq           <= 1'b0;
            err           <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            host_ack  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_grant) begin
                        state_reg     <= ST_ISSUE;
                        last_host_reg <= grant_host;
                        if (grant_host) begin
                            shadow_reg <= host_wdata;
                            eng_txdata <= host_wdata;
                            src_reg    <= SRC_HOST;
                        end else begin
                            eng_txdata <= shadow_reg;
                            src_reg    <= grant_int ? SRC_INT : SRC_POLL;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!eng_busy) begin
                        eng_start   <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        state_reg <= ST_DONE;
                        last_rx   <= eng_rxdata;
                        last_src  <= src_reg;
                        if (src_reg == SRC_HOST) begin
                            host_rdata <= eng_rxdata;
                            host_ack   <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Abandoned transfer: data outputs keep their old values,
                        // but the host is still released.
                        state_reg <= ST_DONE;
                        host_ack  <= (src_reg == SRC_HOST);
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
            if (irq_set)      irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_epl_xfer_scheduler.sv
// Directed bench for epl_xfer_scheduler with a behavioural shift-engine responder.
module tb_epl_xfer_scheduler;

    localparam int POLL_DIV = 16;
    localparam int TMO      = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        poll_en;
    logic        epl_int;
    logic        eng_start;
    logic [31:0] eng_txdata;
    logic        eng_busy;
    logic        eng_done   = 1'b0;
    logic [31:0] eng_rxdata = 32'h0;
    logic [31:0] last_rx;
    logic [1:0]  last_src;
    logic        irq, irq_clr, err, err_clr;

    logic        busy_model = 1'b0;
    logic        busy_force;
    int          eng_lat    = 4;
    logic        eng_mute   = 1'b0;
    logic [31:0] rx_mem [64];
    int          rx_wr      = 0;
    int          rx_rd      = 0;
    logic [1:0]  src_log [$];
    int          n_starts   = 0;
    int          tests      = 0;
    int          fails      = 0;

    always #5 clk = ~clk;
    assign eng_busy = busy_model | busy_force;

    epl_xfer_scheduler #(.POLL_DIV(POLL_DIV), .TIMEOUT(TMO)) dut (
        .csi_MCLK_clk    (clk),
        .rsi_MRST_reset_n(rst_n),
        .host_req        (host_req),
        .host_wdata      (host_wdata),
        .host_ack        (host_ack),
        .host_rdata      (host_rdata),
        .poll_en         (poll_en),
        .epl_int         (epl_int),
        .eng_start       (eng_start),
        .eng_txdata      (eng_txdata),
        .eng_busy        (eng_busy),
        .eng_done        (eng_done),
        .eng_rxdata      (eng_rxdata),
        .last_rx         (last_rx),
        .last_src        (last_src),
        .irq             (irq),
        .irq_clr         (irq_clr),
        .err             (err),
        .err_clr         (err_clr)
    );

    // Engine: busy for eng_lat cycles after a start, then one done pulse with the
    // next queued rx word; logs last_src as seen in the DONE cycle.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (rst_n && eng_start) begin
                n_starts++;
                if (!eng_mute) begin
                    lat = eng_lat;
                    busy_model = 1'b1;
                    repeat (lat - 1) @(negedge clk);
                    if (rx_rd != rx_wr) begin
                        eng_rxdata = rx_mem[rx_rd % 64];
                        rx_rd++;
                    end else begin
                        eng_rxdata = 32'h0BAD_0000;
                    end
                    eng_done = 1'b1;
                    @(negedge clk);
                    eng_done   = 1'b0;
                    busy_model = 1'b0;
                    src_log.push_back(last_src);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_rx(input logic [31:0] v);
        rx_mem[rx_wr % 64] = v;
        rx_wr++;
    endtask

    task automatic host_xfer(input logic [31:0] wd, input logic [31:0] rx, input string tag);
        int cnt;
        push_rx(rx);
        eng_lat    = 4;
        host_req   = 1'b1;
        host_wdata = wd;
        cnt = 0;
        while (!host_ack && cnt < 50) begin
            tick(1);
            cnt++;
        end
        chk(tag, host_ack, 1'b1);
        host_req = 1'b0;
        tick(2);
    endtask

    initial begin
        int cnt;
        int b;
        int starts_before;
        int ackseen;

        rst_n      = 1'b0;
        host_req   = 1'b0;
        host_wdata = 32'h0;
        poll_en    = 1'b0;
        epl_int    = 1'b0;
        irq_clr    = 1'b0;
        err_clr    = 1'b0;
        busy_force = 1'b0;
        tick(3);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_txdata", eng_txdata, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_last_rx", last_rx, 0);
        chk("rst_last_src", last_src, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick(2);

        // Host transfer, engine answers after 70 cycles
        push_rx(32'h1234_5678);
        eng_lat    = 70;
        host_req   = 1'b1;
        host_wdata = 32'hA5A5_0F0F;
        tick(1);
        chk("host_issue_no_start", eng_start, 0);
        tick(1);
        chk("host_start", eng_start, 1);
        chk("host_txdata", eng_txdata, 32'hA5A5_0F0F);
        cnt = 0;
        while (!host_ack && cnt < 200) begin
            tick(1);
            cnt++;
        end
        chk("host_done_latency", cnt, 70);
        chk("host_rdata", host_rdata, 32'h1234_5678);
        chk("host_last_rx", last_rx, 32'h1234_5678);
        chk("host_last_src", last_src, 1);
        chk("host_txdata_stable", eng_txdata, 32'hA5A5_0F0F);
        host_req = 1'b0;
        tick(1);
        chk("host_ack_one_cycle", host_ack, 0);
        tick(2);

        // Poll refresh resends the shadow word
        host_xfer(32'hDEAD_BEEF, 32'h0000_0011, "poll_setup_ack");
        push_rx(32'hCAFE_0001);
        push_rx(32'hCAFE_0002);
        eng_lat = 3;
        ackseen = 0;
        poll_en = 1'b1;
        cnt = 0;
        while (!eng_start && cnt < 100) begin
            tick(1);
            cnt++;
            if (host_ack) ackseen++;
        end
        chk("poll_first_start", cnt, 18);
        chk("poll_txdata1", eng_txdata, 32'hDEAD_BEEF);
        cnt = 0;
        do begin
            tick(1);
            cnt++;
            if (host_ack) ackseen++;
        end while (!eng_start && cnt < 100);
        chk("poll_period", cnt, 16);
        chk("poll_txdata2", eng_txdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (host_ack) ackseen++;
        end
        poll_en = 1'b0;
        chk("poll_last_src", last_src, 3);
        chk("poll_last_rx", last_rx, 32'hCAFE_0002);
        chk("poll_no_host_ack", ackseen, 0);
        chk("poll_host_rdata_kept", host_rdata, 32'h0000_0011);
        tick(4);

        // Interrupt edges during a host transfer merge into one int transfer
        push_rx(32'h0000_1111);
        push_rx(32'h2222_0000);
        eng_lat    = 30;
        host_req   = 1'b1;
        host_wdata = 32'h1357_9BDF;
        cnt = 0;
        while (!eng_start && cnt < 20) begin
            tick(1);
            cnt++;
        end
        chk("int_host_start", cnt, 2);
        tick(3);
        epl_int = 1'b1;
        tick(2);
        epl_int = 1'b0;
        tick(2);
        epl_int = 1'b1;
        tick(2);
        epl_int = 1'b0;
        cnt = 0;
        while (!host_ack && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("int_host_ack", host_ack, 1);
        chk("int_host_src", last_src, 1);
        chk("int_irq_not_yet", irq, 0);
        host_req = 1'b0;
        starts_before = n_starts;
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (!eng_start && cnt < 20);
        chk("int_start_latency", cnt, 3);
        chk("int_txdata_shadow", eng_txdata, 32'h1357_9BDF);
        cnt = 0;
        while (!irq && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("int_irq_latency", cnt, 30);
        chk("int_last_src", last_src, 2);
        chk("int_last_rx", last_rx, 32'h2222_0000);
        chk("int_host_rdata_kept", host_rdata, 32'h0000_1111);
        tick(20);
        chk("int_single_transfer", n_starts - starts_before, 1);

        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        chk("irq_clear", irq, 0);

        // irq set coincides with irq_clr: set must win
        push_rx(32'h2222_0001);
        eng_lat = 5;
        epl_int = 1'b1;
        tick(2);
        epl_int = 1'b0;
        cnt = 0;
        while (!eng_start && cnt < 20) begin
            tick(1);
            cnt++;
        end
        chk("int2_start", eng_start, 1);
        tick(4);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        chk("irq_set_beats_clr", irq, 1);
        chk("int2_last_rx", last_rx, 32'h2222_0001);
        tick(4);

        // Host, int and poll all pending behind a poll carrier
        b = src_log.size();
        push_rx(32'h3000_0003);
        push_rx(32'h1000_0001);
        push_rx(32'h2000_0002);
        push_rx(32'h3000_0033);
        eng_lat = 40;
        poll_en = 1'b1;
        cnt = 0;
        while (!eng_start && cnt < 40) begin
            tick(1);
            cnt++;
        end
        chk("sim_carrier_start", cnt, 18);
        tick(1);
        eng_lat    = 4;
        epl_int    = 1'b1;
        host_req   = 1'b1;
        host_wdata = 32'h5555_AAAA;
        tick(2);
        epl_int = 1'b0;
        cnt = 0;
        while (!host_ack && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("sim_host_ack", host_ack, 1);
        host_req = 1'b0;
        cnt = 0;
        while (src_log.size() < b + 4 && cnt < 150) begin
            tick(1);
            cnt++;
        end
        poll_en = 1'b0;
        chk("sim_order_complete", src_log.size() >= b + 4, 1);
        chk("sim_order0_poll", src_log[b], 3);
        chk("sim_order1_host", src_log[b+1], 1);
        chk("sim_order2_int", src_log[b+2], 2);
        chk("sim_order3_poll", src_log[b+3], 3);
        chk("sim_host_rdata", host_rdata, 32'h1000_0001);
        tick(20);

        // Same, with host_req held across its ack: host, int, host, poll
        b = src_log.size();
        push_rx(32'h3000_0003);
        push_rx(32'h1000_0001);
        push_rx(32'h2000_0002);
        push_rx(32'h1000_0011);
        push_rx(32'h3000_0033);
        eng_lat = 40;
        poll_en = 1'b1;
        cnt = 0;
        while (!eng_start && cnt < 40) begin
            tick(1);
            cnt++;
        end
        chk("rr_carrier_start", cnt, 18);
        tick(1);
        eng_lat    = 4;
        epl_int    = 1'b1;
        host_req   = 1'b1;
        host_wdata = 32'h6666_BBBB;
        tick(2);
        epl_int = 1'b0;
        cnt = 0;
        while (!host_ack && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("rr_host_ack1", host_ack, 1);
        tick(1);
        cnt = 0;
        while (!host_ack && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("rr_host_ack2", host_ack, 1);
        host_req = 1'b0;
        cnt = 0;
        while (src_log.size() < b + 5 && cnt < 150) begin
            tick(1);
            cnt++;
        end
        poll_en = 1'b0;
        chk("rr_order_complete", src_log.size() >= b + 5, 1);
        chk("rr_order0_poll", src_log[b], 3);
        chk("rr_order1_host", src_log[b+1], 1);
        chk("rr_order2_int", src_log[b+2], 2);
        chk("rr_order3_host", src_log[b+3], 1);
        chk("rr_order4_poll", src_log[b+4], 3);
        chk("rr_host_rdata", host_rdata, 32'h1000_0011);
        tick(20);

        // Timeout: engine never answers
        host_xfer(32'h0F0F_0000, 32'h4444_4444, "tmo_setup_ack");
        eng_mute   = 1'b1;
        host_req   = 1'b1;
        host_wdata = 32'h0F0F_0F0F;
        cnt = 0;
        while (!eng_start && cnt < 20) begin
            tick(1);
            cnt++;
        end
        chk("tmo_start", cnt, 2);
        cnt = 0;
        ackseen = 0;
        while (!host_ack && cnt < TMO + 20) begin
            if (err) ackseen++;
            tick(1);
            cnt++;
        end
        chk("tmo_latency", cnt, TMO);
        chk("tmo_no_early_err", ackseen, 0);
        chk("tmo_err", err, 1);
        chk("tmo_host_rdata_kept", host_rdata, 32'h4444_4444);
        chk("tmo_last_rx_kept", last_rx, 32'h4444_4444);
        chk("tmo_last_src_kept", last_src, 1);
        chk("tmo_irq_kept", irq, 1);
        host_req = 1'b0;
        tick(1);
        chk("tmo_ack_one_cycle", host_ack, 0);
        chk("tmo_err_sticky", err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("tmo_err_clear", err, 0);
        tick(3);

        // Busy engine holds off the start; reset in WAIT clears everything
        busy_force = 1'b1;
        host_req   = 1'b1;
        host_wdata = 32'h7777_0000;
        tick(6);
        chk("busy_holds_start", eng_start, 0);
        busy_force = 1'b0;
        tick(1);
        chk("busy_release_start", eng_start, 1);
        chk("busy_txdata", eng_txdata, 32'h7777_0000);
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("arst_eng_start", eng_start, 0);
        chk("arst_eng_txdata", eng_txdata, 0);
        chk("arst_host_ack", host_ack, 0);
        chk("arst_host_rdata", host_rdata, 0);
        chk("arst_last_rx", last_rx, 0);
        chk("arst_last_src", last_src, 0);
        chk("arst_irq", irq, 0);
        chk("arst_err", err, 0);
        tick(2);
        host_req = 1'b0;
        rst_n    = 1'b1;
        tick(5);
        chk("post_rst_no_start", eng_start, 0);
        chk("post_rst_no_ack", host_ack, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
